// File: rtl/seg_pkg.sv
// Shared constants and helpers for the segment-display arbiter and its arbiter sub-block.
package seg_pkg;

   localparam int unsigned SEG_DATA_W = 32;
   localparam int unsigned SEG_DIGITS = 8;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   typedef enum logic {
      StIdle = ST_IDLE,
      StHold = ST_HOLD
   } state_e;

   // Width of a down-counter that must hold values 0..hold; never returns zero.
   function automatic int unsigned cnt_width(input int unsigned hold);
      int unsigned w;
      w = $clog2(hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: scans upward from last+1 with wrap, grants the first request.
module rr_arbiter_n
   import seg_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] k;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      k            = '0;
      // i runs 1..N so the previously granted index is considered last.
      for (int unsigned i = 1; i <= N; i++) begin
         k = IW'((32'(last) + i) % N);
         if (!any && req[k]) begin
            any             = 1'b1;
            grant_onehot[k] = 1'b1;
            grant_idx       = k;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of one 8-digit display between N_REQ producers, with a dwell per word.
// Define SEG_ARB_SRC_TAG_EN to show the owning requester index in the leftmost digit.
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_CLOCKS = 50_000_000
) (
   input  logic                        clk,
   input  logic                        rst_i,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [SEG_DATA_W*N_REQ-1:0] req_data_i,
   output logic [N_REQ-1:0]            req_ready_o,
   input  logic                        skip_i,
   output logic [SEG_DATA_W-1:0]       data_o,
   output logic [2:0]                  src_o,
   output logic                        shown_o,
   output logic                        busy_o
);

   localparam int unsigned IdxW = $clog2(N_REQ);
   localparam int unsigned CntW = cnt_width(HOLD_CLOCKS);
   localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CLOCKS - 1);
   localparam logic [IdxW-1:0] LastRst = IdxW'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("seg_display_arbiter: N_REQ must be in 2..8");
   end
   if (HOLD_CLOCKS < 1) begin : g_bad_hold
      $error("seg_display_arbiter: HOLD_CLOCKS must be >= 1");
   end

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [SEG_DATA_W-1:0] word_q, word_d;
   logic [2:0]            src_q, src_d;
   logic [IdxW-1:0]       last_q, last_d;
   logic                  shown_q, shown_d;

   logic [N_REQ-1:0]      grant_onehot;
   logic [IdxW-1:0]       grant_idx;
   logic                  grant_any;
   logic [N_REQ-1:0]      ready;
   logic [SEG_DATA_W-1:0] word_sel;

   rr_arbiter_n #(
      .N  (N_REQ),
      .IW (IdxW)
   ) u_arb (
      .req          (req_valid_i),
      .last         (last_q),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   always_comb begin
      word_sel = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (grant_onehot[k]) begin
            word_sel = req_data_i[SEG_DATA_W*k +: SEG_DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      src_d   = src_q;
      last_d  = last_q;
      shown_d = shown_q;
      ready   = '0;
      unique case (state_q)
         StIdle: begin
            ready = grant_onehot;
            if (grant_any) begin
`ifdef SEG_ARB_SRC_TAG_EN
               // Upper nibble of the word is dropped; the owner index takes its place.
               word_d = {1'b0, 3'(grant_idx), word_sel[SEG_DATA_W-5:0]};
`else
               word_d = word_sel;
`endif
               src_d   = 3'(grant_idx);
               last_d  = grant_idx;
               shown_d = 1'b1;
               cnt_d   = CntLoad;
               state_d = StHold;
            end
         end
         StHold: begin
            // skip_i takes priority over the remaining dwell.
            if (skip_i || cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         word_q  <= '0;
         src_q   <= '0;
         last_q  <= LastRst;
         shown_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         src_q   <= src_d;
         last_q  <= last_d;
         shown_q <= shown_d;
      end
   end

   assign req_ready_o = rst_i ? '0 : ready;
   assign data_o      = word_q;
   assign src_o       = src_q;
   assign shown_o     = shown_q;
   assign busy_o      = (state_q == StHold);

endmodule
